zip_add_n: RTL and testbench

Parametrised N-channel stream zip-and-add stage. It pairs one token from each of `CH` valid/ready input streams in arrival order and emits their sum on a single output stream. It sits between stream producers and consumers in generated dataflow pipelines. Compared with the fixed two-input zip-add, it adds per-channel elastic buffers so that producers with different rates do not stall each other token by token. It also has a selectable wrap/saturate arithmetic mode and an overflow flag.

---
 rtl/zip_add_n.sv | 99 +++++++++
 tb/tb_zip_add_n.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zip_add_n.sv
// N-channel stream zip-and-add: per-channel elastic FIFOs joined into one output
// register that carries the sum of one token per channel, with wrap or saturate.
module zip_add_n #(
  parameter int WIDTH = 8,
  parameter int CH    = 2,
  parameter int DEPTH = 2,
  parameter int SAT   = 0
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_overflow,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = WIDTH + $clog2(CH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [CH*WIDTH-1:0] w_heads;
  logic [CH-1:0]       w_nonempty;
  logic                w_fire;
  logic [SW-1:0]       w_sum;
  logic                w_ovf;
  logic [WIDTH-1:0]    w_res;

  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_ovf;
  logic                r_out_valid;

  assign w_fire = (&w_nonempty) & (~r_out_valid | out_ready);

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             w_wr;

    // Ready depends only on this channel's registered count, never on the join.
    assign in_ready[gi]   = (r_cnt < DEPTH_C) & nrst;
    assign w_wr           = in_valid[gi] & in_ready[gi];
    assign w_nonempty[gi] = (r_cnt != '0);
    assign w_heads[gi*WIDTH +: WIDTH] = r_mem[r_rptr];

    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= in_data[gi*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_wr)   r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
        if (w_fire) r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
        if (w_wr && !w_fire)      r_cnt <= r_cnt + 1'b1;
        else if (!w_wr && w_fire) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < CH; i++) begin
      w_sum = w_sum + SW'(w_heads[i*WIDTH +: WIDTH]);
    end
  end

  assign w_ovf = |w_sum[SW-1:WIDTH];
  assign w_res = ((SAT != 0) && w_ovf) ? '1 : w_sum[WIDTH-1:0];

  // Data and flag hold while stalled; only the valid bit drains on out_ready.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_fire) begin
      r_out_data  <= w_res;
      r_out_ovf   <= w_ovf;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data     = r_out_data;
  assign out_overflow = r_out_ovf;
  assign out_valid    = r_out_valid;

endmodule

// File: tb/tb_zip_add_n.sv
// Bench for zip_add_n: scoreboard on the CH=2 wrap instance plus directed
// overflow checks on saturating and three-channel instances.
module tb_zip_add_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst;

  logic [15:0] in_data0;
  logic [1:0]  in_valid0, in_ready0;
  logic [7:0]  out_data0;
  logic        out_overflow0, out_valid0, out_ready0;

  logic [15:0] in_data1;
  logic [1:0]  in_valid1, in_ready1;
  logic [7:0]  out_data1;
  logic        out_overflow1, out_valid1, out_ready1;

  logic [23:0] in_data2;
  logic [2:0]  in_valid2, in_ready2;
  logic [7:0]  out_data2;
  logic        out_overflow2, out_valid2, out_ready2;

  zip_add_n #(.WIDTH(8), .CH(2), .DEPTH(2), .SAT(0)) u0 (
    .clk(clk), .nrst(nrst), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_overflow(out_overflow0),
    .out_valid(out_valid0), .out_ready(out_ready0));

  zip_add_n #(.WIDTH(8), .CH(2), .DEPTH(2), .SAT(1)) u1 (
    .clk(clk), .nrst(nrst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_overflow(out_overflow1),
    .out_valid(out_valid1), .out_ready(out_ready1));

  zip_add_n #(.WIDTH(8), .CH(3), .DEPTH(2), .SAT(0)) u2 (
    .clk(clk), .nrst(nrst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out_data(out_data2), .out_overflow(out_overflow2),
    .out_valid(out_valid2), .out_ready(out_ready2));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [8:0] exp_q[$];

  logic [1:0] last_acc;
  int         na, nb;
  logic [7:0] a_val, b_val, b_inc;

  // Scoreboard for u0: accepted tokens pair up in order into expected {ovf,sum}.
  always @(negedge clk) begin : mon_blk
    logic [8:0] e;
    logic [8:0] s;
    if (nrst) begin
      if (out_valid0 && out_ready0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_spurious: got out_data=%0d ovf=%0b with no token pair outstanding",
                   out_data0, out_overflow0);
        end else begin
          e = exp_q.pop_front();
          if ({out_overflow0, out_data0} !== e) begin
            miscompares++;
            $display("FAIL sb_output: got data=%0d ovf=%0b, expected data=%0d ovf=%0b",
                     out_data0, out_overflow0, e[7:0], e[8]);
          end
        end
      end
      if (in_valid0[0] && in_ready0[0]) qa.push_back(in_data0[7:0]);
      if (in_valid0[1] && in_ready0[1]) qb.push_back(in_data0[15:8]);
      while (qa.size() > 0 && qb.size() > 0) begin
        s = {1'b0, qa.pop_front()} + {1'b0, qb.pop_front()};
        exp_q.push_back(s);
      end
    end
  end

  always @(negedge nrst) begin
    qa.delete();
    qb.delete();
    exp_q.delete();
  end

  // One cycle of u0 stimulus; an offer not yet accepted keeps its valid and data.
  task automatic step(input logic [1:0] want, input logic ordy);
    @(posedge clk); #1;
    if (last_acc[0]) a_val = a_val + 8'd1;
    if (last_acc[1]) b_val = b_val + b_inc;
    in_valid0  = (in_valid0 & ~last_acc) | want;
    in_data0   = {b_val, a_val};
    out_ready0 = ordy;
    @(negedge clk); #1;
    last_acc = in_valid0 & in_ready0;
    na += int'(last_acc[0]);
    nb += int'(last_acc[1]);
  endtask

  task automatic drain();
    logic [1:0] pend, w;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      pend = in_valid0 & ~last_acc;
      if (in_valid0 == 2'b00 && na == nb && qa.size() == 0 && qb.size() == 0 &&
          exp_q.size() == 0 && !out_valid0) begin
        done = 1'b1;
      end else begin
        w[0] = (na + int'(pend[0])) < (nb + int'(pend[1]));
        w[1] = (nb + int'(pend[1])) < (na + int'(pend[0]));
        step(w, 1'b1);
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain: pending outputs=%0d out_valid=%0b, expected 0 and 0 within budget",
               exp_q.size(), out_valid0);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    #1 nrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid0 = 2'($urandom_range(0, 3));
      in_data0  = 16'($urandom);
      @(negedge clk); #1;
      vectors++;
      if (out_valid0 !== 1'b0 || out_data0 !== 8'd0 || in_ready0 !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_hold: valid=%0b data=%0d in_ready=%b, expected 0 0 00",
                 out_valid0, out_data0, in_ready0);
      end
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    in_valid0 = 2'b00;
    @(negedge clk); #1;
    vectors++;
    if (in_ready0 !== 2'b11 || out_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b valid=%0b, expected 11 0", in_ready0, out_valid0);
    end
    last_acc = 2'b00;
    na = 0;
    nb = 0;
  endtask

  task automatic test_matched();
    logic [7:0] expd;
    a_val = 8'd0;
    b_val = 8'd0;
    b_inc = 8'd2;
    for (int k = 0; k < 12; k++) begin
      step(2'b11, 1'b1);
      vectors++;
      if (k < 2) begin
        if (out_valid0 !== 1'b0) begin
          miscompares++;
          $display("FAIL matched_latency k=%0d: out_valid=%0b, expected 0", k, out_valid0);
        end
      end else begin
        expd = 8'(3 * (k - 2));
        if (out_valid0 !== 1'b1 || out_data0 !== expd) begin
          miscompares++;
          $display("FAIL matched_stream k=%0d: valid=%0b data=%0d, expected 1 %0d",
                   k, out_valid0, out_data0, expd);
        end
      end
    end
    drain();
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    in_data0 = {8'd100, 8'd200};  in_valid0 = 2'b11;  out_ready0 = 1'b1;
    in_data1 = {8'd100, 8'd200};  in_valid1 = 2'b11;
    in_data2 = {8'd255, 8'd255, 8'd255};  in_valid2 = 3'b111;
    @(negedge clk);
    @(posedge clk); #1;
    in_data0 = {8'd27, 8'd100};
    in_data1 = {8'd27, 8'd100};
    in_valid2 = 3'b000;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid0 = 2'b00;
    in_valid1 = 2'b00;
    @(negedge clk); #1;
    vectors++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'd44 || out_overflow0 !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_wrap: valid=%0b data=%0d ovf=%0b, expected 1 44 1",
               out_valid0, out_data0, out_overflow0);
    end
    vectors++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'd255 || out_overflow1 !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sat: valid=%0b data=%0d ovf=%0b, expected 1 255 1",
               out_valid1, out_data1, out_overflow1);
    end
    vectors++;
    if (out_valid2 !== 1'b1 || out_data2 !== 8'd253 || out_overflow2 !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_ch3: valid=%0b data=%0d ovf=%0b, expected 1 253 1",
               out_valid2, out_data2, out_overflow2);
    end
    @(posedge clk); #1;
    @(negedge clk); #1;
    vectors++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'd127 || out_overflow0 !== 1'b0) begin
      miscompares++;
      $display("FAIL noovf_wrap: valid=%0b data=%0d ovf=%0b, expected 1 127 0",
               out_valid0, out_data0, out_overflow0);
    end
    vectors++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'd127 || out_overflow1 !== 1'b0) begin
      miscompares++;
      $display("FAIL noovf_sat: valid=%0b data=%0d ovf=%0b, expected 1 127 0",
               out_valid1, out_data1, out_overflow1);
    end
    last_acc = 2'b00;
    na = 0;
    nb = 0;
  endtask

  task automatic test_rate_mismatch();
    bit saw_full;
    bit prev_ov;
    int consec;
    saw_full = 1'b0;
    prev_ov  = 1'b0;
    consec   = 0;
    a_val = 8'd10;
    b_val = 8'd90;
    b_inc = 8'd1;
    for (int c = 0; c < 20; c++) begin
      step({(c % 2 == 0), 1'b1}, 1'b1);
      if (in_ready0[0] === 1'b0) saw_full = 1'b1;
      if (out_valid0 && prev_ov) consec++;
      prev_ov = out_valid0;
    end
    vectors++;
    if (saw_full !== 1'b1) begin
      miscompares++;
      $display("FAIL rate_a_full: in_ready[0] low seen=%0b, expected 1", saw_full);
    end
    vectors++;
    if (consec !== 0) begin
      miscompares++;
      $display("FAIL rate_spacing: back-to-back outputs=%0d, expected 0", consec);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] frozen_d;
    logic       frozen_o;
    a_val = 8'd40;
    b_val = 8'd7;
    b_inc = 8'd3;
    for (int c = 0; c < 4; c++) step(2'b11, 1'b1);
    step(2'b11, 1'b0);
    frozen_d = out_data0;
    frozen_o = out_overflow0;
    vectors++;
    if (out_valid0 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_start: out_valid=%0b, expected 1", out_valid0);
    end
    for (int c = 0; c < 4; c++) begin
      step(2'b11, 1'b0);
      vectors++;
      if (out_valid0 !== 1'b1 || out_data0 !== frozen_d || out_overflow0 !== frozen_o) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d: valid=%0b data=%0d, expected 1 %0d",
                 c, out_valid0, out_data0, frozen_d);
      end
    end
    vectors++;
    if (in_ready0 !== 2'b00) begin
      miscompares++;
      $display("FAIL bp_full: in_ready=%b, expected 00", in_ready0);
    end
    for (int c = 0; c < 4; c++) begin
      step(2'b11, 1'b1);
      vectors++;
      if (out_valid0 !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_resume c=%0d: out_valid=%0b, expected 1", c, out_valid0);
      end
    end
    drain();
  endtask

  task automatic test_mid_reset();
    a_val = 8'd1;
    b_val = 8'd2;
    b_inc = 8'd2;
    for (int c = 0; c < 4; c++) step(2'b11, 1'b0);
    nrst = 1'b0;
    in_valid0 = 2'b00;
    #1;
    vectors++;
    if (out_valid0 !== 1'b0 || out_data0 !== 8'd0 || in_ready0 !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_async: valid=%0b data=%0d in_ready=%b, expected 0 0 00",
               out_valid0, out_data0, in_ready0);
    end
    @(negedge clk); #1;
    nrst = 1'b1;
    last_acc = 2'b00;
    na = 0;
    nb = 0;
    a_val = 8'd50;
    b_val = 8'd60;
    step(2'b11, 1'b1);
    vectors++;
    if (out_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_stale: out_valid=%0b, expected 0", out_valid0);
    end
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    vectors++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'd110) begin
      miscompares++;
      $display("FAIL midrst_first: valid=%0b data=%0d, expected 1 110", out_valid0, out_data0);
    end
    drain();
  endtask

  initial begin
    in_data0 = '0;  in_valid0 = '0;  out_ready0 = 1'b1;
    in_data1 = '0;  in_valid1 = '0;  out_ready1 = 1'b1;
    in_data2 = '0;  in_valid2 = '0;  out_ready2 = 1'b1;
    last_acc = 2'b00;
    na = 0;
    nb = 0;
    a_val = '0;
    b_val = '0;
    b_inc = 8'd1;
    test_reset();
    test_matched();
    test_overflow();
    test_rate_mismatch();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule
